// File: rtl/trace_uart_tx.sv
// trace_uart_tx: snapshots one core debug step per strobe and
// ships it as an 18-byte 8N1 UART frame.
module trace_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_stepStrobe,
  input  logic [31:0] i_pcOut,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_aluOut,
  input  logic [31:0] i_writeBack,
  input  logic [3:0]  i_flags,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [7:0]  o_dropCount
);

  localparam logic [15:0] LAST_CNT =
    16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  byte_q, byte_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wb_q, wb_d;
  logic [3:0]  flags_q, flags_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  drop_q, drop_d;

  logic        strobe_en;
  logic        bit_done;
  logic [7:0]  cur_byte;

  assign strobe_en = i_enable & i_stepStrobe;
  assign bit_done  = (baud_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    alu_d     = alu_q;
    wb_d      = wb_q;
    flags_d   = flags_q;
    overrun_d = overrun_q;
    drop_d    = drop_q;

    if (state_q != IDLE) begin
      baud_d = bit_done ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (strobe_en) begin
          state_d = START;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
          pc_d    = i_pcOut;
          inst_d  = i_inst;
          alu_d   = i_aluOut;
          wb_d    = i_writeBack;
          flags_d = i_flags;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (byte_q == 5'd17) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            byte_d  = byte_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes while busy are lost; the frame in flight is untouched.
    if (strobe_en && state_q != IDLE) begin
      overrun_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_comb begin
    case (byte_q)
      5'd0:    cur_byte = SYNC_BYTE;
      5'd1:    cur_byte = pc_q[31:24];
      5'd2:    cur_byte = pc_q[23:16];
      5'd3:    cur_byte = pc_q[15:8];
      5'd4:    cur_byte = pc_q[7:0];
      5'd5:    cur_byte = inst_q[31:24];
      5'd6:    cur_byte = inst_q[23:16];
      5'd7:    cur_byte = inst_q[15:8];
      5'd8:    cur_byte = inst_q[7:0];
      5'd9:    cur_byte = alu_q[31:24];
      5'd10:   cur_byte = alu_q[23:16];
      5'd11:   cur_byte = alu_q[15:8];
      5'd12:   cur_byte = alu_q[7:0];
      5'd13:   cur_byte = wb_q[31:24];
      5'd14:   cur_byte = wb_q[23:16];
      5'd15:   cur_byte = wb_q[15:8];
      5'd16:   cur_byte = wb_q[7:0];
      5'd17:   cur_byte = {4'b0000, flags_q};
      default: cur_byte = 8'h00;
    endcase
  end

  // Line is decoded straight from state so reset forces it high at once.
  always_comb begin
    case (state_q)
      START:   o_tx = 1'b0;
      DATA:    o_tx = cur_byte[bit_q];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy      = (state_q != IDLE);
  assign o_overrun   = overrun_q;
  assign o_dropCount = drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      byte_q    <= 5'd0;
      pc_q      <= 32'd0;
      inst_q    <= 32'd0;
      alu_q     <= 32'd0;
      wb_q      <= 32'd0;
      flags_q   <= 4'd0;
      overrun_q <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      alu_q     <= alu_d;
      wb_q      <= wb_d;
      flags_q   <= flags_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_trace_uart_tx.sv
// tb_trace_uart_tx: scoreboard bench; a UART monitor decodes the
// fast instance and each scenario task compares against its queue.
module tb_trace_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        strobe = 1'b0;
  logic        b_strobe = 1'b0;
  logic [31:0] pc = '0, inst = '0;
  logic [31:0] alu = '0, wb = '0;
  logic [3:0]  flags = '0;
  logic        tx, busy, ovr;
  logic [7:0]  dcnt;
  logic        b_tx, b_busy, b_ovr;
  logic [7:0]  b_dcnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];

  always #5 clk = ~clk;

  trace_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .i_enable(en),
    .i_stepStrobe(strobe), .i_pcOut(pc),
    .i_inst(inst), .i_aluOut(alu),
    .i_writeBack(wb), .i_flags(flags),
    .o_tx(tx), .o_busy(busy),
    .o_overrun(ovr), .o_dropCount(dcnt)
  );

  trace_uart_tx #(.CLKS_PER_BIT(434)) dut434 (
    .clk(clk), .reset(reset), .i_enable(1'b1),
    .i_stepStrobe(b_strobe), .i_pcOut(pc),
    .i_inst(inst), .i_aluOut(alu),
    .i_writeBack(wb), .i_flags(flags),
    .o_tx(b_tx), .o_busy(b_busy),
    .o_overrun(b_ovr), .o_dropCount(b_dcnt)
  );

  // Receiver: samples mid-bit, pushes {stop, data}.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          d[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back({tx, d});
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic void push_frame(
    input logic [31:0] p, i, a, w,
    input logic [3:0] f);
    exp_q.push_back(8'hA5);
    for (int s = 24; s >= 0; s -= 8) exp_q.push_back(p[s+:8]);
    for (int s = 24; s >= 0; s -= 8) exp_q.push_back(i[s+:8]);
    for (int s = 24; s >= 0; s -= 8) exp_q.push_back(a[s+:8]);
    for (int s = 24; s >= 0; s -= 8) exp_q.push_back(w[s+:8]);
    exp_q.push_back({4'b0000, f});
  endfunction

  // Caller is at a negedge; returns at the negedge after the accept edge.
  task automatic pulse(input logic [31:0] p, i, a, w,
                       input logic [3:0] f);
    pc = p; inst = i; alu = a; wb = w; flags = f;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic wait_idle(output int k);
    k = 1;
    while (busy === 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx got=%b exp=1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (ovr !== 1'b0) begin
      failures++; $display("FAIL reset_ovr got=%b exp=0", ovr);
    end
    checks++;
    if (dcnt !== 8'd0) begin
      failures++; $display("FAIL reset_dcnt got=%0d exp=0", dcnt);
    end
    pulse(32'h1, 32'h2, 32'h3, 32'h4, 4'h5);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL midreset_tx got=%b exp=1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL midreset_busy got=%b exp=0", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
  endtask

  task automatic test_single_frame;
    int k;
    @(negedge clk);
    push_frame(32'h4, 32'h00500093, 32'h5, 32'h5, 4'b1000);
    pulse(32'h4, 32'h00500093, 32'h5, 32'h5, 4'b1000);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      failures++;
      $display("FAIL sf_start got=busy%b/tx%b exp=busy1/tx0", busy, tx);
    end
    wait_idle(k);
    checks++;
    if (k != 721) begin
      failures++; $display("FAIL sf_busy_fall got=N+%0d exp=N+721", k);
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        failures++; $display("FAIL sf_byte got=none exp=%h", e);
      end else begin
        logic [8:0] r;
        r = rx_q.pop_front();
        if (r !== {1'b1, e}) begin
          failures++; $display("FAIL sf_byte got=%h exp=%h", r, {1'b1, e});
        end
      end
    end
  endtask

  task automatic test_enable;
    int k;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    @(negedge clk);
    pulse(32'hDEAD, 32'hBEEF, 32'h1, 32'h2, 4'h3);
    repeat (CPB * 3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL en_idle got=busy%b/tx%b exp=busy0/tx1", busy, tx);
    end
    en = 1'b1;
    push_frame(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 4'hF);
    pulse(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 4'hF);
    en = 1'b0;
    repeat (50) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      pulse(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
    end
    checks++;
    if (dcnt !== 8'd0 || ovr !== 1'b0) begin
      failures++;
      $display("FAIL en_busy_drop got=%0d/%b exp=0/0", dcnt, ovr);
    end
    wait_idle(k);
    repeat (2) @(negedge clk);
    en = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        failures++; $display("FAIL en_byte got=none exp=%h", e);
      end else begin
        logic [8:0] r;
        r = rx_q.pop_front();
        if (r !== {1'b1, e}) begin
          failures++; $display("FAIL en_byte got=%h exp=%h", r, {1'b1, e});
        end
      end
    end
  endtask

  task automatic test_drop;
    int k;
    @(negedge clk);
    push_frame(32'hCAFEF00D, 32'h00000013, 32'h7, 32'h8, 4'b0101);
    pulse(32'hCAFEF00D, 32'h00000013, 32'h7, 32'h8, 4'b0101);
    repeat (99) @(negedge clk);
    pulse(32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h1, 4'b1111);
    checks++;
    if (ovr !== 1'b1 || dcnt !== 8'd1) begin
      failures++;
      $display("FAIL drop_one got=%b/%0d exp=1/1", ovr, dcnt);
    end
    wait_idle(k);
    push_frame(32'hA, 32'hB, 32'hC, 32'hD, 4'h2);
    pulse(32'hA, 32'hB, 32'hC, 32'hD, 4'h2);
    for (int n = 0; n < 300; n++) begin
      pulse(n, ~n, 32'h0, 32'h0, 4'h9);
      @(negedge clk);
    end
    checks++;
    if (ovr !== 1'b1 || dcnt !== 8'd255) begin
      failures++;
      $display("FAIL drop_sat got=%b/%0d exp=1/255", ovr, dcnt);
    end
    wait_idle(k);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        failures++; $display("FAIL drop_byte got=none exp=%h", e);
      end else begin
        logic [8:0] r;
        r = rx_q.pop_front();
        if (r !== {1'b1, e}) begin
          failures++; $display("FAIL drop_byte got=%h exp=%h", r, {1'b1, e});
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic [7:0] dc0;
    @(negedge clk);
    dc0 = dcnt;
    push_frame(32'h80000000, 32'hFEDCBA98, 32'h1, 32'h2, 4'h1);
    pulse(32'h80000000, 32'hFEDCBA98, 32'h1, 32'h2, 4'h1);
    wait_idle(k);
    checks++;
    if (k != 721) begin
      failures++; $display("FAIL b2b_first_len got=N+%0d exp=N+721", k);
    end
    push_frame(32'h00000100, 32'h0000006F, 32'h3C, 32'h104, 4'b0010);
    pulse(32'h00000100, 32'h0000006F, 32'h3C, 32'h104, 4'b0010);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start got=busy%b/tx%b exp=busy1/tx0", busy, tx);
    end
    checks++;
    if (dcnt !== dc0) begin
      failures++; $display("FAIL b2b_dcnt got=%0d exp=%0d", dcnt, dc0);
    end
    wait_idle(k);
    repeat (2) @(negedge clk);
    checks++;
    if (rx_q.size() != 36) begin
      failures++; $display("FAIL b2b_count got=%0d exp=36", rx_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        failures++; $display("FAIL b2b_byte got=none exp=%h", e);
      end else begin
        logic [8:0] r;
        r = rx_q.pop_front();
        if (r !== {1'b1, e}) begin
          failures++; $display("FAIL b2b_byte got=%h exp=%h", r, {1'b1, e});
        end
      end
    end
  endtask

  task automatic test_bit_timing;
    logic [9:0] pat;
    int bad;
    pat = 10'b1101001010;
    @(negedge clk);
    checks++;
    if (b_tx !== 1'b1 || b_busy !== 1'b0) begin
      failures++; $display("FAIL bt_idle got=%b exp=1", b_tx);
    end
    b_strobe = 1'b1;
    @(negedge clk);
    b_strobe = 1'b0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 434; c++) begin
        if (b_tx !== pat[b]) bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL bt_bit%0d got=%0d_wrong_cycles exp=0 level=%b",
                 b, bad, pat[b]);
      end
    end
    checks++;
    if (b_tx !== 1'b0) begin
      failures++; $display("FAIL bt_next_start got=%b exp=0", b_tx);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_enable();
    test_drop();
    test_back_to_back();
    test_bit_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Debug trace serializer that sits directly downstream of the KLP32V1 core's debug outputs.
- On each processor step strobe it snapshots pc, instruction, ALU result, writeback value and control flags, then transmits them as a fixed 18-byte frame over a UART 8N1 line.
- Gives the board an off-chip, per-instruction execution log without halting the core.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200 baud); legal range 2..65535.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock (50 MHz), single clock domain.
- reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  when low, strobes are ignored and not counted as drops.
- i_stepStrobe  input  1  one-clk pulse marking a completed processor step; snapshot inputs are valid in this cycle.
- i_pcOut  input  32  program counter.
- i_inst  input  32  instruction word.
- i_aluOut  input  32  ALU result.
- i_writeBack  input  32  register-file writeback data.
- i_flags  input  4  {RegWEn, memRW, BrEq, BrLT}, MSB first.
- o_tx  output  1  UART serial line; idles high.
- o_busy  output  1  frame in progress.
- o_overrun  output  1  sticky; set when a strobe is dropped.
- o_dropCount  output  8  count of dropped strobes, saturating at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - o_tx=1, o_busy=0, o_overrun=0, o_dropCount=0.
  - FSM returns to IDLE; counters and snapshot clear.
  - Reset mid-frame aborts immediately and o_tx goes high; no partial byte completes.
- Strobe acceptance:
  - A strobe is accepted when i_enable=1, i_stepStrobe=1 and the FSM is in IDLE.
  - In the accept cycle N, all i_* data inputs are registered into the snapshot.
  - o_busy=1 from cycle N+1. The start bit of byte 0 drives o_tx=0 from cycle N+1.
- Drops:
  - A strobe with i_enable=1 while busy is dropped.
  - o_overrun is set on the next cycle and o_dropCount increments, holding at 255.
  - The snapshot is not modified and the frame in flight continues unchanged.
- Frame order, 18 bytes:
  - SYNC_BYTE.
  - pc[31:24], pc[23:16], pc[15:8], pc[7:0].
  - inst, 4 bytes, MSB byte first.
  - aluOut, 4 bytes, MSB byte first.
  - writeBack, 4 bytes, MSB byte first.
  - {4'b0000, flags}.
- Byte format:
  - Start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit held exactly CLKS_PER_BIT cycles.
  - No idle gap between consecutive bytes.
  - Whole frame = 180*CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after 1 bit time.
  - DATA -> STOP after 8 bit times.
  - STOP -> START (next byte) if byte index < 17, else IDLE.
  - Byte index is 5 bits and bit index is 3 bits; both reset at each accept.
- End of frame:
  - o_busy falls to 0 in the first cycle after the last stop bit completes (FSM in IDLE).
  - A strobe in that same cycle is accepted, so back-to-back frames have zero gap.
- Clearing drop status:
  - o_overrun and o_dropCount clear only on reset.
  - i_enable going low mid-frame does not abort the frame.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. There is no fractional-baud correction.

Test Plan:
1. Reset/idle: hold reset=0 for 5 cycles, then release -> o_tx=1, o_busy=0, o_dropCount=0. Also assert reset mid-byte -> o_tx=1 in the same cycle.
2. Single frame (CLKS_PER_BIT=4): strobe with pc=32'h00000004, inst=32'h00500093, aluOut=32'h5, writeBack=32'h5, flags=4'b1000 -> decoded bytes A5 00 00 00 04 00 50 00 93 00 00 00 05 00 00 00 05 08. Frame spans 720 cycles, and o_busy falls at cycle N+721.
3. Drop during frame: a second strobe 100 cycles into the frame, with different data -> frame bytes unchanged, o_overrun=1, o_dropCount=1. A further 300 strobes -> o_dropCount saturates at 255.
4. Back-to-back: strobe in the exact cycle o_busy falls -> accepted, start bit on the next cycle, o_dropCount unchanged.
5. Enable gating: i_enable=0 with strobes, both idle and busy -> no frame starts, o_dropCount stays 0, o_tx stays 1.
6. Bit timing: CLKS_PER_BIT=434, send byte SYNC_BYTE -> every bit measures exactly 434 cycles. Line pattern is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop).
